// File: rtl/parity_frame_generator_if.sv
// Handshake bundle for parity_frame_generator.
// master: payload source / frame sink side; slave: the framer.
//
// Signals
//   in_data/in_wide/in_valid -> in_ready    payload push handshake
//   out_data/out_valid       -> out_ready   frame pop handshake
//   fifo_level, word_count                  status from the framer
//   inject_err                              parity corruption request
//                                           (PARITY_ERR_INJECT_EN only)
interface parity_frame_generator_if #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [15:0]        in_data;
    logic               in_wide;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        out_data;
    logic               out_valid;
    logic               out_ready;
    logic [LW-1:0]      fifo_level;
    logic [COUNT_W-1:0] word_count;
`ifdef PARITY_ERR_INJECT_EN
    logic               inject_err;
`endif

    modport master (
        output in_data,
        output in_wide,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  fifo_level,
        input  word_count
`ifdef PARITY_ERR_INJECT_EN
        ,
        output inject_err
`endif
    );

    modport slave (
        input  in_data,
        input  in_wide,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output fifo_level,
        output word_count
`ifdef PARITY_ERR_INJECT_EN
        ,
        input  inject_err
`endif
    );
endinterface

// File: rtl/parity_frame_generator.sv
// Transmit-side even-parity framer with a DEPTH-entry frame FIFO.
// Ports: clk, rst_n (async, active low), bus (parity_frame_generator_if.slave).
//
// Frames: narrow {1'b0, 6'b0, p, d[7:0]}, wide {1'b1, d[13:0], p};
// p makes the XOR of all 16 frame bits zero.
// Frames are encoded on push; the FIFO holds finished frames.
// Optional macro PARITY_ERR_INJECT_EN enables bus.inject_err, which
// inverts the parity bit of the frame pushed in that cycle.
module parity_frame_generator #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    parity_frame_generator_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [15:0]        mem_q [DEPTH];
    logic [15:0]        mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic        push;
    logic        pop;
    logic        inj;
    logic        p_narrow;
    logic        p_wide;
    logic [15:0] frame;
    logic        unused_in_hi;

    // Bits [15:14] are never part of any payload.
    assign unused_in_hi = ^bus.in_data[15:14];

    // Both flags come only from the stored level, so in_ready never
    // depends on out_ready and an empty FIFO never falls through.
    assign bus.in_ready   = (level_q != FULL);
    assign bus.out_valid  = (level_q != '0);
    assign bus.out_data   = bus.out_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign bus.fifo_level = level_q;
    assign bus.word_count = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

`ifdef PARITY_ERR_INJECT_EN
    assign inj = bus.inject_err;
`else
    assign inj = 1'b0;
`endif

    always_comb begin
        p_narrow = ^bus.in_data[7:0];
        p_wide   = ~^bus.in_data[13:0];
        if (bus.in_wide) begin
            frame = {1'b1, bus.in_data[13:0], p_wide ^ inj};
        end else begin
            frame = {7'b0000000, p_narrow ^ inj, bus.in_data[7:0]};
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = frame;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q + COUNT_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_parity_frame_generator.sv
// Self-checking bench for parity_frame_generator.
// Scoreboard queue of expected frames, compared on every pop.
module tb_parity_frame_generator;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    parity_frame_generator_if #(.DEPTH(4), .COUNT_W(16)) bus ();

    parity_frame_generator #(.DEPTH(4), .COUNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] sb[$];
    logic [15:0] exp_cnt;
    logic        cur_inj;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d,
                                          input logic w, input logic inj);
        logic [15:0] f;
        if (w) begin
            f[15]   = 1'b1;
            f[14:1] = d[13:0];
            f[0]    = 1'b0;
        end else begin
            f       = 16'h0000;
            f[7:0]  = d[7:0];
        end
        // choose the bit so that the full word has even parity
        if (w) f[0] = ^f;
        else   f[8] = ^f;
        if (inj) begin
            if (w) f[0] = ~f[0];
            else   f[8] = ~f[8];
        end
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("stale_frame", 32'(bus.out_data), 32'hdead);
                end else begin
                    logic [16:0] e;
                    e = sb.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e[15:0]));
                    chk("parity", 32'(^bus.out_data), 32'(e[16]));
                    exp_cnt = exp_cnt + 16'd1;
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back({cur_inj,
                              model(bus.in_data, bus.in_wide, cur_inj)});
        end
    end

    task automatic drive(input logic [15:0] d, input logic w,
                         input logic inj);
        bus.in_data  = d;
        bus.in_wide  = w;
        bus.in_valid = 1'b1;
        cur_inj      = inj;
`ifdef PARITY_ERR_INJECT_EN
        bus.inject_err = inj;
`endif
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        cur_inj      = 1'b0;
`ifdef PARITY_ERR_INJECT_EN
        bus.inject_err = 1'b0;
`endif
    endtask

    task automatic send(input logic [15:0] d, input logic w,
                        input logic inj);
        int n;
        n = 0;
        @(posedge clk); #1;
        drive(d, w, inj);
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        idle_in();
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("drain_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        exp_cnt       = 16'd0;
        cur_inj       = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_wide   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef PARITY_ERR_INJECT_EN
        bus.inject_err = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_count", 32'(bus.word_count), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // narrow frames, one-cycle latency into an empty FIFO
        bus.out_ready = 1'b1;
        send(16'h0003, 1'b0, 1'b0);
        chk("narrow0_valid", 32'(bus.out_valid), 32'd1);
        chk("narrow0_data", 32'(bus.out_data), 32'h0003);
        send(16'hff07, 1'b0, 1'b0);
        chk("narrow1_data", 32'(bus.out_data), 32'h0107);
        drain();

        // wide frames
        send(16'hc001, 1'b1, 1'b0);
        chk("wide0_data", 32'(bus.out_data), 32'h8002);
        send(16'h0000, 1'b1, 1'b0);
        chk("wide1_data", 32'(bus.out_data), 32'h8001);
        drain();
        chk("count_after_4", 32'(bus.word_count), 32'd4);

        // full FIFO back-pressure
        bus.out_ready = 1'b0;
        send(16'h0011, 1'b0, 1'b0);
        send(16'h1234, 1'b1, 1'b0);
        send(16'h00fe, 1'b0, 1'b0);
        send(16'h3fff, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(16'h0055, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_level", 32'(bus.fifo_level), 32'd4);
        @(posedge clk); #1;
        idle_in();
        chk("full_hold_level", 32'(bus.fifo_level), 32'd4);
        drain();
        chk("full_count", 32'(bus.word_count), 32'd8);
        chk("full_in_ready_back", 32'(bus.in_ready), 32'd1);

        // concurrent push and pop at level 2
        bus.out_ready = 1'b0;
        send(16'h0021, 1'b0, 1'b0);
        send(16'h0a5a, 1'b1, 1'b0);
        begin
            logic [15:0] c0;
            c0 = exp_cnt;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                drive(16'($urandom), 1'($urandom), 1'b0);
                bus.out_ready = 1'b1;
                @(negedge clk);
                chk("conc_level", 32'(bus.fifo_level), 32'd2);
            end
            @(posedge clk); #1;
            idle_in();
            bus.out_ready = 1'b0;
            chk("conc_level_end", 32'(bus.fifo_level), 32'd2);
            chk("conc_count", 32'(bus.word_count), 32'(c0 + 16'd10));
        end
        drain();

        // reset in the middle of a stream
        bus.out_ready = 1'b0;
        send(16'h0001, 1'b0, 1'b0);
        send(16'h0002, 1'b0, 1'b0);
        send(16'h0003, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_level", 32'(bus.fifo_level), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_level", 32'(bus.fifo_level), 32'd0);
        chk("mid_rst_count", 32'(bus.word_count), 32'd0);
        sb.delete();
        exp_cnt = 16'd0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_count", 32'(bus.word_count), 32'd0);

`ifdef PARITY_ERR_INJECT_EN
        send(16'h0007, 1'b0, 1'b1);
        chk("inject_data", 32'(bus.out_data), 32'h0007);
        drain();
`endif
        send(16'h0080, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
